rps_match_ctrl: RTL and testbench

- Referee and sequencer for a two-player ROCK/PAPER/SCISSORS match.
- Arbitrates move submissions from two requesters over a valid/ready handshake and validates each 64-bit ASCII move name against the list {ROCK, PAPER, SCISSORS}.
- Judges each round, keeps scores and a round count, and declares the match winner.
- Sits between the player front-ends and the scoreboard/display logic.

---
 rtl/rps_match_if.sv | 35 +++
 rtl/rps_match_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_rps_match_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rps_match_if.sv
// Player-side handshake and result bus for the rock/paper/scissors referee.
// The player/host side drives through master; the controller drives through slave.
interface rps_match_if;
  logic        en;
  logic        start;
  logic        p0_valid;
  logic        p1_valid;
  logic [63:0] p0_name;
  logic [63:0] p1_name;
  logic        p0_ready;
  logic        p1_ready;
  logic        p0_err;
  logic        p1_err;
  logic        round_valid;
  logic [1:0]  round_result;
  logic [1:0]  move0;
  logic [1:0]  move1;
  logic [3:0]  score0;
  logic [3:0]  score1;
  logic [7:0]  round_cnt;
  logic        match_done;
  logic [1:0]  winner;

  modport master (
    output en, start, p0_valid, p1_valid, p0_name, p1_name,
    input  p0_ready, p1_ready, p0_err, p1_err, round_valid, round_result,
           move0, move1, score0, score1, round_cnt, match_done, winner
  );

  modport slave (
    input  en, start, p0_valid, p1_valid, p0_name, p1_name,
    output p0_ready, p1_ready, p0_err, p1_err, round_valid, round_result,
           move0, move1, score0, score1, round_cnt, match_done, winner
  );
endinterface

// File: rtl/rps_match_ctrl.sv
// Two-player rock/paper/scissors referee: collects and validates moves,
// judges rounds, keeps score and declares the match winner. All outputs registered.
module rps_match_ctrl #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  rps_match_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, JUDGE, DONE} state_t;

  typedef enum logic [1:0] {
    MV_NONE     = 2'b00,
    MV_ROCK     = 2'b01,
    MV_PAPER    = 2'b10,
    MV_SCISSORS = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    RES_DRAW = 2'b00,
    RES_P0   = 2'b01,
    RES_P1   = 2'b10
  } result_t;

  localparam logic [63:0] NAME_ROCK     = 64'h0000_0000_524F_434B;
  localparam logic [63:0] NAME_PAPER    = 64'h0000_0050_4150_4552;
  localparam logic [63:0] NAME_SCISSORS = 64'h5343_4953_534F_5253;
  localparam logic [3:0]  WIN_T         = 4'(WIN_TARGET);
  localparam logic [7:0]  MAX_R         = 8'(MAX_ROUNDS);

  // Exact match only; case variants and zero fall through to MV_NONE.
  function automatic move_t decode(input logic [63:0] name);
    case (name)
      NAME_ROCK:     return MV_ROCK;
      NAME_PAPER:    return MV_PAPER;
      NAME_SCISSORS: return MV_SCISSORS;
      default:       return MV_NONE;
    endcase
  endfunction

  function automatic result_t judge(input move_t a, input move_t b);
    if (a == b) return RES_DRAW;
    if ((a == MV_ROCK     && b == MV_SCISSORS) ||
        (a == MV_SCISSORS && b == MV_PAPER)    ||
        (a == MV_PAPER    && b == MV_ROCK))
      return RES_P0;
    return RES_P1;
  endfunction

  state_t      state;
  move_t       slot0, slot1;
  logic        ready0, ready1;
  logic        err0, err1;
  logic        round_valid_q;
  result_t     result_q;
  move_t       move0_q, move1_q;
  logic [3:0]  score0_q, score1_q;
  logic [7:0]  round_cnt_q;
  logic        match_done_q;
  logic [1:0]  winner_q;

  move_t       dec0, dec1;
  logic        fill0, fill1, bad0, bad1;
  logic        both_full;
  result_t     res;
  logic [3:0]  score0_nx, score1_nx;
  logic [7:0]  round_cnt_nx;
  logic        finish;
  logic [1:0]  winner_nx;

  always_comb begin
    // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
    dec0 = decode(bus.p0_name);
    dec1 = decode(bus.p1_name);
    // ready is only ever high in COLLECT, so it doubles as the accept qualifier.
    fill0 = bus.p0_valid && ready0 && (dec0 != MV_NONE);
    fill1 = bus.p1_valid && ready1 && (dec1 != MV_NONE);
    bad0  = bus.p0_valid && ready0 && (dec0 == MV_NONE);
    bad1  = bus.p1_valid && ready1 && (dec1 == MV_NONE);
    both_full = ((slot0 != MV_NONE) || fill0) && ((slot1 != MV_NONE) || fill1);

    res          = judge(slot0, slot1);
    score0_nx    = score0_q + 4'(res == RES_P0);
    score1_nx    = score1_q + 4'(res == RES_P1);
    round_cnt_nx = round_cnt_q + 8'd1;
    finish       = (score0_nx == WIN_T) || (score1_nx == WIN_T) || (round_cnt_nx == MAX_R);

    winner_nx = 2'b00;
    if (score0_nx > score1_nx)      winner_nx = 2'b01;
    else if (score1_nx > score0_nx) winner_nx = 2'b10;
  end

  // NOTE: the move slots are reset along with the control state so a match never sees a stale move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      slot0         <= MV_NONE;
      slot1         <= MV_NONE;
      ready0        <= 1'b0;
      ready1        <= 1'b0;
      err0          <= 1'b0;
      err1          <= 1'b0;
      round_valid_q <= 1'b0;
      result_q      <= RES_DRAW;
      move0_q       <= MV_NONE;
      move1_q       <= MV_NONE;
      score0_q      <= 4'd0;
      score1_q      <= 4'd0;
      round_cnt_q   <= 8'd0;
      match_done_q  <= 1'b0;
      winner_q      <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      round_valid_q <= 1'b0;
      err0          <= 1'b0;
      err1          <= 1'b0;

      if (!bus.en) begin
        // Abort: scores and round count are kept for display until the next start.
        state        <= IDLE;
        slot0        <= MV_NONE;
        slot1        <= MV_NONE;
        ready0       <= 1'b0;
        ready1       <= 1'b0;
        match_done_q <= 1'b0;
        winner_q     <= 2'b00;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              state        <= COLLECT;
              slot0        <= MV_NONE;
              slot1        <= MV_NONE;
              ready0       <= 1'b1;
              ready1       <= 1'b1;
              score0_q     <= 4'd0;
              score1_q     <= 4'd0;
              round_cnt_q  <= 8'd0;
              match_done_q <= 1'b0;
              winner_q     <= 2'b00;
            end
          end

          COLLECT: begin
            if (fill0) begin
              slot0  <= dec0;
              ready0 <= 1'b0;
            end
            if (fill1) begin
              slot1  <= dec1;
              ready1 <= 1'b0;
            end
            err0 <= bad0;
            err1 <= bad1;
            if (both_full) state <= JUDGE;
          end

          JUDGE: begin
            move0_q       <= slot0;
            move1_q       <= slot1;
            result_q      <= res;
            score0_q      <= score0_nx;
            score1_q      <= score1_nx;
            round_cnt_q   <= round_cnt_nx;
            round_valid_q <= 1'b1;
            if (finish) begin
              state        <= DONE;
              match_done_q <= 1'b1;
              winner_q     <= winner_nx;
            end else begin
              state  <= COLLECT;
              slot0  <= MV_NONE;
              slot1  <= MV_NONE;
              ready0 <= 1'b1;
              ready1 <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.p0_ready     = ready0;
  assign bus.p1_ready     = ready1;
  assign bus.p0_err       = err0;
  assign bus.p1_err       = err1;
  assign bus.round_valid  = round_valid_q;
  assign bus.round_result = result_q;
  assign bus.move0        = move0_q;
  assign bus.move1        = move1_q;
  assign bus.score0       = score0_q;
  assign bus.score1       = score1_q;
  assign bus.round_cnt    = round_cnt_q;
  assign bus.match_done   = match_done_q;
  assign bus.winner       = winner_q;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Bench for rps_match_ctrl: a round-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rps_match_ctrl;

  localparam int WT = 3;
  localparam int MR = 9;

  localparam logic [63:0] N_ROCK  = 64'("ROCK");
  localparam logic [63:0] N_PAPER = 64'("PAPER");
  localparam logic [63:0] N_SCI   = 64'("SCISSORS");
  localparam logic [63:0] N_LROCK = 64'("rock");
  localparam logic [63:0] N_ZERO  = 64'd0;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  rps_match_if bus ();
  rps_match_if bus2 ();

  rps_match_ctrl #(.WIN_TARGET(WT), .MAX_ROUNDS(MR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  rps_match_ctrl #(.WIN_TARGET(3), .MAX_ROUNDS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (round-level view) ----------------
  // Moves are indices 0=rock 1=paper 2=scissors; -1 marks an empty slot.
  // Player 0 wins when (m0 - m1) mod 3 == 1.
  int phase;   // 0 idle, 1 collecting, 2 judging, 3 match over
  int s0, s1;
  int sc0, sc1, rc;
  int e_m0, e_m1, e_res, e_win;
  bit e_rv, e_err0, e_err1, e_done, e_rdy0, e_rdy1;

  function automatic int name_idx(input logic [63:0] n);
    if (n == N_ROCK)  return 0;
    if (n == N_PAPER) return 1;
    if (n == N_SCI)   return 2;
    return -1;
  endfunction

  task automatic model_reset();
    phase = 0; s0 = -1; s1 = -1; sc0 = 0; sc1 = 0; rc = 0;
    e_m0 = 0; e_m1 = 0; e_res = 0; e_win = 0;
    e_rv = 0; e_err0 = 0; e_err1 = 0; e_done = 0; e_rdy0 = 0; e_rdy1 = 0;
  endtask

  task automatic model_step();
    int d;
    e_rv = 0; e_err0 = 0; e_err1 = 0;
    if (!bus.en) begin
      phase = 0; s0 = -1; s1 = -1; e_done = 0; e_win = 0;
    end else if (phase == 0 || phase == 3) begin
      if (bus.start) begin
        phase = 1; s0 = -1; s1 = -1; sc0 = 0; sc1 = 0; rc = 0; e_done = 0; e_win = 0;
      end
    end else if (phase == 1) begin
      if (bus.p0_valid && s0 < 0) begin
        if (name_idx(bus.p0_name) >= 0) s0 = name_idx(bus.p0_name);
        else e_err0 = 1;
      end
      if (bus.p1_valid && s1 < 0) begin
        if (name_idx(bus.p1_name) >= 0) s1 = name_idx(bus.p1_name);
        else e_err1 = 1;
      end
      if (s0 >= 0 && s1 >= 0) phase = 2;
    end else begin
      d     = (s0 - s1 + 3) % 3;
      e_res = d;
      e_m0  = s0 + 1;
      e_m1  = s1 + 1;
      if (d == 1) sc0++;
      if (d == 2) sc1++;
      rc++;
      e_rv = 1;
      if (sc0 == WT || sc1 == WT || rc == MR) begin
        phase  = 3;
        e_done = 1;
        e_win  = (sc0 > sc1) ? 1 : ((sc1 > sc0) ? 2 : 0);
      end else begin
        phase = 1; s0 = -1; s1 = -1;
      end
    end
    e_rdy0 = (phase == 1) && (s0 < 0);
    e_rdy1 = (phase == 1) && (s1 < 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every cycle out of reset, all outputs of the main DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("p0_ready",     bus.p0_ready,     64'(e_rdy0));
        check("p1_ready",     bus.p1_ready,     64'(e_rdy1));
        check("p0_err",       bus.p0_err,       64'(e_err0));
        check("p1_err",       bus.p1_err,       64'(e_err1));
        check("round_valid",  bus.round_valid,  64'(e_rv));
        check("round_result", bus.round_result, 64'(e_res));
        check("move0",        bus.move0,        64'(e_m0));
        check("move1",        bus.move1,        64'(e_m1));
        check("score0",       bus.score0,       64'(sc0));
        check("score1",       bus.score1,       64'(sc1));
        check("round_cnt",    bus.round_cnt,    64'(rc));
        check("match_done",   bus.match_done,   64'(e_done));
        check("winner",       bus.winner,       64'(e_win));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Offer moves for one edge; returns in the cycle after acceptance.
  task automatic send(input bit v0, input logic [63:0] n0, input bit v1, input logic [63:0] n1);
    bus.p0_valid = v0; bus.p0_name = n0;
    bus.p1_valid = v1; bus.p1_name = n1;
    step();
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
  endtask

  // Full round; returns in the cycle round_valid is high.
  task automatic play(input logic [63:0] n0, input logic [63:0] n1);
    send(1'b1, n0, 1'b1, n1);
    step();
  endtask

  task automatic play2(input logic [63:0] n0, input logic [63:0] n1);
    bus2.p0_valid = 1'b1; bus2.p0_name = n0;
    bus2.p1_valid = 1'b1; bus2.p1_name = n1;
    step();
    bus2.p0_valid = 1'b0; bus2.p1_valid = 1'b0;
    step();
  endtask

  task automatic start_match();
    bus.en = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;  bus.start = 1'b0;  bus.p0_valid = 1'b0;  bus.p1_valid = 1'b0;
    bus.p0_name = '0;  bus.p1_name = '0;
    bus2.en = 1'b0; bus2.start = 1'b0; bus2.p0_valid = 1'b0; bus2.p1_valid = 1'b0;
    bus2.p0_name = '0; bus2.p1_name = '0;
    repeat (3) step();
    check("reset_ready", bus.p0_ready, 64'd0);
    check("reset_done",  bus.match_done, 64'd0);
    rst_n = 1'b1;
    step();

    // Rock beats scissors, both moves on the same edge.
    start_match();
    check("t1_ready0", bus.p0_ready, 64'd1);
    send(1'b1, N_ROCK, 1'b1, N_SCI);
    check("t1_judge_no_rv", bus.round_valid, 64'd0);
    step();
    check("t1_rv",     bus.round_valid,  64'd1);
    check("t1_result", bus.round_result, 64'h1);
    check("t1_move0",  bus.move0,        64'h1);
    check("t1_move1",  bus.move1,        64'h3);
    check("t1_score0", bus.score0,       64'd1);
    check("t1_rc",     bus.round_cnt,    64'd1);

    // Lowercase and zero names are rejected; the slots stay open.
    send(1'b1, N_LROCK, 1'b1, N_ZERO);
    check("t2_err0",   bus.p0_err,   64'd1);
    check("t2_err1",   bus.p1_err,   64'd1);
    check("t2_ready0", bus.p0_ready, 64'd1);
    step();
    check("t2_err0_clr", bus.p0_err, 64'd0);
    play(N_PAPER, N_ROCK);
    check("t2_result", bus.round_result, 64'h1);
    check("t2_score0", bus.score0,       64'd2);

    // Draw: no score change, round count still advances.
    play(N_PAPER, N_PAPER);
    check("t3_result", bus.round_result, 64'h0);
    check("t3_score0", bus.score0,       64'd2);
    check("t3_score1", bus.score1,       64'd0);
    check("t3_rc",     bus.round_cnt,    64'd3);

    // Player 1 takes three in a row and the match.
    play(N_ROCK, N_PAPER);
    play(N_SCI, N_ROCK);
    check("t4_not_done", bus.match_done, 64'd0);
    play(N_PAPER, N_SCI);
    check("t4_done",   bus.match_done, 64'd1);
    check("t4_winner", bus.winner,     64'h2);
    check("t4_score1", bus.score1,     64'd3);
    check("t4_ready0", bus.p0_ready,   64'd0);
    check("t4_ready1", bus.p1_ready,   64'd0);
    step();

    // Restart from DONE clears everything.
    start_match();
    check("t5_score1", bus.score1,     64'd0);
    check("t5_rc",     bus.round_cnt,  64'd0);
    check("t5_done",   bus.match_done, 64'd0);
    check("t5_ready1", bus.p1_ready,   64'd1);
    play(N_SCI, N_PAPER);
    check("t5_score0", bus.score0, 64'd1);

    // Abort with one move in: back to idle, scores held, no round pulse.
    send(1'b1, N_ROCK, 1'b0, N_ZERO);
    check("t6_ready0", bus.p0_ready, 64'd0);
    check("t6_ready1", bus.p1_ready, 64'd1);
    bus.en = 1'b0;
    bus.p1_valid = 1'b1; bus.p1_name = N_PAPER;
    step();
    check("t6_idle_ready1", bus.p1_ready,    64'd0);
    step();
    check("t6_no_rv",       bus.round_valid, 64'd0);
    check("t6_score_hold",  bus.score0,      64'd1);
    check("t6_rc_hold",     bus.round_cnt,   64'd1);
    bus.p1_valid = 1'b0;
    bus.en = 1'b1;
    step();
    check("t6_no_autostart", bus.p0_ready, 64'd0);

    // Start during COLLECT is ignored and the filled slot is kept.
    start_match();
    send(1'b1, N_ROCK, 1'b0, N_ZERO);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t7_slot_kept", bus.p0_ready, 64'd0);
    send(1'b1, N_PAPER, 1'b1, N_SCI);
    step();
    check("t7_result", bus.round_result, 64'h1);
    check("t7_move0",  bus.move0,        64'h1);

    // Asynchronous reset mid-collect, between clock edges.
    play(N_SCI, N_PAPER);
    send(1'b1, N_ROCK, 1'b0, N_ZERO);
    #3;
    rst_n = 1'b0;
    #1;
    check("t8_ready1", bus.p1_ready,     64'd0);
    check("t8_score0", bus.score0,       64'd0);
    check("t8_rc",     bus.round_cnt,    64'd0);
    check("t8_move0",  bus.move0,        64'd0);
    check("t8_result", bus.round_result, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Round cap of two on the second instance: two draws end the match tied.
    bus2.en = 1'b1; bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    play2(N_PAPER, N_PAPER);
    check("t9_rc1",   bus2.round_cnt,  64'd1);
    check("t9_open",  bus2.match_done, 64'd0);
    play2(N_ROCK, N_ROCK);
    check("t9_done",   bus2.match_done, 64'd1);
    check("t9_winner", bus2.winner,     64'h0);
    check("t9_rc2",    bus2.round_cnt,  64'd2);
    check("t9_ready0", bus2.p0_ready,   64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
